// File: rtl/fetch_ctrl.sv
// fetch_ctrl: credit-limited sequential RV32I prefetch into the prefetch FIFO; redirect flushes and drops stale responses.
// Response->FIFO write is combinational; req_valid_o uses registered credit only. FETCH_ERR_EN adds a FAULT stop on bus error.
module fetch_ctrl #(
  parameter int C_XLEN            = 32,
  parameter int C_FIFO_DEPTH_X    = 2,
  parameter int C_MAX_OUTSTANDING = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 redirect_i,
  input  logic [C_XLEN-1:0]    redirect_pc_i,
  input  logic                 halt_i,
  output logic                 idle_o,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic [C_XLEN-1:0]    req_addr_o,
  input  logic                 resp_valid_i,
  input  logic [31:0]          resp_data_i,
  input  logic                 resp_err_i,
  output logic                 fifo_flush_o,
  output logic                 fifo_wr_o,
  output logic [C_XLEN+32:0]   fifo_din_o,
  input  logic                 fifo_rd_i
);

  localparam int D  = 2 ** C_FIFO_DEPTH_X;
  localparam int LW = C_FIFO_DEPTH_X + 1;
  localparam int CW = $clog2(C_MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN
`ifdef FETCH_ERR_EN
    ,S_FAULT
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [LW-1:0]       level_q, level_d;
  logic [CW-1:0]       live_q, live_d;
  logic [CW-1:0]       disc_q, disc_d;
  logic [C_XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [C_XLEN-1:0]   resp_pc_q, resp_pc_d;

  logic                accept;
  logic                resp_drop;
  logic                resp_live;
  logic                pop;
  logic                err_bit;
  logic [31:0]         credit_used;
  logic [31:0]         outstanding;
  logic [C_XLEN-1:0]   redirect_pc_al;

  // Credit is computed from registered counters only, so req_valid_o never
  // combinationally depends on redirect, responses or pops.
  assign credit_used = 32'(level_q) + 32'(live_q);
  assign outstanding = 32'(live_q) + 32'(disc_q);
  assign req_valid_o = (state_q == S_FETCH) && (credit_used < 32'(D))
                       && (outstanding < 32'(C_MAX_OUTSTANDING));
  assign req_addr_o  = fetch_pc_q;
  assign idle_o      = (state_q == S_IDLE);

  assign accept    = req_valid_o & req_ready_i;
  // A response with nothing live and nothing to discard has no slot; never write it.
  assign resp_drop = resp_valid_i & (disc_q != '0);
  assign resp_live = resp_valid_i & (disc_q == '0) & (live_q != '0);
  assign pop       = fifo_rd_i & (level_q != '0);

  assign redirect_pc_al = {redirect_pc_i[C_XLEN-1:2], 2'b00};

`ifdef FETCH_ERR_EN
  assign err_bit = resp_err_i;
  logic [1:0] unused_bits;
  assign unused_bits = redirect_pc_i[1:0];
`else
  assign err_bit = 1'b0;
  logic [2:0] unused_bits;
  assign unused_bits = {resp_err_i, redirect_pc_i[1:0]};
`endif

  assign fifo_flush_o = reset_i | redirect_i;
  assign fifo_wr_o    = resp_live & ~redirect_i;
  assign fifo_din_o   = {err_bit, resp_pc_q, resp_data_i};

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    live_d     = live_q;
    disc_d     = disc_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    if (redirect_i) begin
      // Everything still in flight, including this cycle's accept, becomes stale.
      level_d    = '0;
      live_d     = '0;
      disc_d     = disc_q + live_q + CW'(accept) - CW'(resp_drop | resp_live);
      fetch_pc_d = redirect_pc_al;
      resp_pc_d  = redirect_pc_al;
      state_d    = halt_i ? S_DRAIN : S_FETCH;
    end else begin
      level_d = level_q + LW'(fifo_wr_o) - LW'(pop);
      live_d  = live_q + CW'(accept) - CW'(resp_live);
      disc_d  = disc_q - CW'(resp_drop);
      if (accept)    fetch_pc_d = fetch_pc_q + C_XLEN'(4);
      if (resp_live) resp_pc_d  = resp_pc_q + C_XLEN'(4);
      case (state_q)
        S_FETCH: if (halt_i) state_d = S_DRAIN;
        S_DRAIN: if ((live_d == '0) && (disc_d == '0)) state_d = S_IDLE;
        default: state_d = state_q;
      endcase
`ifdef FETCH_ERR_EN
      if (fifo_wr_o && resp_err_i) begin
        disc_d  = disc_d + live_d;
        live_d  = '0;
        state_d = S_FAULT;
      end
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      level_q    <= '0;
      live_q     <= '0;
      disc_q     <= '0;
      fetch_pc_q <= '0;
      resp_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      live_q     <= live_d;
      disc_q     <= disc_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
    end
  end

  a_level_bound: assert property (@(posedge clk_i) disable iff (reset_i)
    32'(level_q) <= 32'(D));
  a_outstanding_bound: assert property (@(posedge clk_i) disable iff (reset_i)
    outstanding <= 32'(C_MAX_OUTSTANDING));
  a_resp_has_slot: assert property (@(posedge clk_i) disable iff (reset_i)
    resp_valid_i |-> ((live_q != '0) || (disc_q != '0)));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: per-cycle vector table for control outputs, plus a scoreboard
// of expected FIFO entries pushed on accepted requests and popped on FIFO writes.
module tb_fetch_ctrl;
`ifdef FETCH_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_i, redirect_i, halt_i, req_ready_i, resp_valid_i, resp_err_i, fifo_rd_i;
  logic [31:0] redirect_pc_i, resp_data_i;
  logic        idle_o, req_valid_o, fifo_flush_o, fifo_wr_o;
  logic [31:0] req_addr_o;
  logic [64:0] fifo_din_o;

  always #5 clk = ~clk;

  fetch_ctrl #(.C_XLEN(32), .C_FIFO_DEPTH_X(2), .C_MAX_OUTSTANDING(4)) dut (
    .clk_i(clk), .reset_i(reset_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .halt_i(halt_i), .idle_o(idle_o), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .req_addr_o(req_addr_o), .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i),
    .resp_err_i(resp_err_i), .fifo_flush_o(fifo_flush_o), .fifo_wr_o(fifo_wr_o),
    .fifo_din_o(fifo_din_o), .fifo_rd_i(fifo_rd_i)
  );

  typedef struct {
    bit rdr; logic [31:0] pc; bit halt; bit rdy; bit rd; bit men;
    bit vld; bit idle; bit flush; bit wr;
  } vec_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  vec_t        tbl[$];
  mreq_t       mem_q[$];
  logic [64:0] exp_q[$];
  int          n_vec, n_bad, cyc;
  logic [31:0] exp_addr, err_addr;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic add(input bit rdr, input logic [31:0] pc, input bit halt, input bit rdy,
                     input bit rd, input bit men, input bit vld, input bit idle,
                     input bit flush, input bit wr);
    vec_t v;
    v.rdr = rdr; v.pc = pc; v.halt = halt; v.rdy = rdy; v.rd = rd; v.men = men;
    v.vld = vld; v.idle = idle; v.flush = flush; v.wr = wr;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // One clock: apply inputs, let the memory model respond, check at negedge+1.
  task automatic tick(input vec_t v);
    mreq_t       m;
    logic [64:0] e;
    redirect_i = v.rdr; redirect_pc_i = v.pc; halt_i = v.halt;
    req_ready_i = v.rdy; fifo_rd_i = v.rd;
    @(negedge clk);
    resp_valid_i = 1'b0; resp_data_i = '0; resp_err_i = 1'b0;
    if (v.men && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m = mem_q.pop_front();
      resp_valid_i = 1'b1;
      resp_data_i  = data_of(m.addr);
      resp_err_i   = (m.addr == err_addr);
    end
    #1;
    chk("req_valid", 65'(req_valid_o), 65'(v.vld));
    chk("idle", 65'(idle_o), 65'(v.idle));
    chk("fifo_flush", 65'(fifo_flush_o), 65'(v.flush));
    chk("fifo_wr", 65'(fifo_wr_o), 65'(v.wr));
    if (req_valid_o && req_ready_i) begin
      chk("req_addr", 65'(req_addr_o), 65'(exp_addr));
      m.addr = req_addr_o; m.due = cyc + 1;
      mem_q.push_back(m);
      if (!redirect_i)
        exp_q.push_back({(ERR_EN && exp_addr == err_addr), exp_addr, data_of(exp_addr)});
      exp_addr = exp_addr + 32'd4;
    end
    if (fifo_wr_o) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL fifo_din cycle %0d: got write %0h expected no write", cyc, fifo_din_o);
      end else begin
        e = exp_q.pop_front();
        chk("fifo_din", fifo_din_o, e);
        if (ERR_EN && e[64]) exp_q.delete();
      end
    end
    if (redirect_i) begin
      exp_q.delete();
      exp_addr = redirect_pc_i & ~32'h3;
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  initial begin
    reset_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; halt_i = 1'b0; req_ready_i = 1'b0;
    resp_valid_i = 1'b0; resp_data_i = '0; resp_err_i = 1'b0; fifo_rd_i = 1'b0;
    n_vec = 0; n_bad = 0; cyc = 0; exp_addr = '0; err_addr = 32'h404;

    // rdr pc halt rdy rd men | vld idle flush wr
    add(1,'h100,0,1,0,1, 0,1,1,0);                 // start fetching at 0x100
    add(0,0,0,1,0,1, 1,0,0,0);
    add(0,0,0,1,0,1, 1,0,0,1);
    add(0,0,0,1,0,1, 1,0,0,1);
    add(0,0,0,1,0,1, 1,0,0,1);
    add(0,0,0,1,0,1, 0,0,0,1);                     // level+live == 4
    add(0,0,0,1,0,1, 0,0,0,0);
    add(0,0,0,1,0,1, 0,0,0,0);
    add(0,0,0,1,1,1, 0,0,0,0);                     // one pop frees one credit
    add(0,0,0,1,0,1, 1,0,0,0);
    add(0,0,0,1,0,1, 0,0,0,1);
    add(0,0,0,1,1,0, 0,0,0,0);                     // drain FIFO, memory stalled
    add(0,0,0,1,1,0, 1,0,0,0);
    add(0,0,0,1,1,0, 1,0,0,0);
    add(0,0,0,1,1,0, 1,0,0,0);
    add(1,'h203,0,0,0,0, 1,0,1,0);                 // redirect with 3 outstanding
    add(0,0,0,1,0,1, 1,0,0,0);
    add(0,0,0,1,0,1, 1,0,0,0);
    add(0,0,0,1,0,1, 1,0,0,0);
    add(0,0,0,1,0,1, 1,0,0,1);
    add(0,0,0,1,0,1, 0,0,0,1);
    add(0,0,0,1,0,1, 0,0,0,1);
    add(0,0,0,1,0,1, 0,0,0,1);
    add(0,0,0,1,0,1, 0,0,0,0);
    add(0,0,0,1,1,1, 0,0,0,0);
    add(0,0,0,1,1,1, 1,0,0,0);
    add(1,'h300,0,1,0,1, 1,0,1,0);                 // redirect + accept + response
    add(0,0,0,1,0,1, 1,0,0,0);
    add(0,0,0,1,0,1, 1,0,0,1);
    add(0,0,0,1,0,0, 1,0,0,0);
    add(0,0,1,0,0,0, 1,0,0,0);                     // halt with 2 outstanding
    add(0,0,0,1,0,1, 0,0,0,1);
    add(0,0,0,1,0,1, 0,0,0,1);
    add(0,0,0,1,0,1, 0,1,0,0);
    add(0,0,1,1,0,1, 0,1,0,0);                     // halt ignored in IDLE
    add(0,0,1,1,0,1, 0,1,0,0);
    add(1,'h400,0,1,0,1, 0,1,1,0);                 // second response carries err
    add(0,0,0,1,0,1, 1,0,0,0);
    add(0,0,0,1,0,1, 1,0,0,1);
    add(0,0,0,1,0,1, 1,0,0,1);
    add(0,0,0,1,0,1, !ERR_EN,0,0,!ERR_EN);
    add(0,0,0,1,0,1, 0,0,0,!ERR_EN);
    add(1,'h500,0,1,0,1, 0,0,1,0);
    add(0,0,0,1,0,1, 1,0,0,0);
    add(0,0,0,1,0,1, 1,0,0,1);

    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_idle", 65'(idle_o), 65'd1);
    chk("rst_req_valid", 65'(req_valid_o), 65'd0);
    chk("rst_req_addr", 65'(req_addr_o), 65'd0);
    chk("rst_fifo_wr", 65'(fifo_wr_o), 65'd0);
    chk("rst_fifo_flush", 65'(fifo_flush_o), 65'd1);
    @(posedge clk); #1;
    reset_i = 1'b0;

    foreach (tbl[i]) tick(tbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-prefetch controller for the RV32I front end. It issues sequential word fetches on a valid/ready request bus and writes in-order responses into the prefetch FIFO as {err, pc, instr} entries. Issue is credit-limited so the FIFO can never overflow. On a redirect it flushes the FIFO and drops stale in-flight responses. It sits between the instruction memory port and the prefetch FIFO, whose read side feeds decode.

## Interface
- C_XLEN, 32, address/PC width.
- C_FIFO_DEPTH_X, 2, log2 of the prefetch FIFO depth; depth D = 2**C_FIFO_DEPTH_X.
- C_MAX_OUTSTANDING, 4, max accepted-but-unanswered requests (live + discard), ≥1.
- clk_i  input  1  clock; all state on rising edge.
- reset_i  input  1  synchronous, active-high reset.
- redirect_i  input  1  load new fetch PC; flush.
- redirect_pc_i  input  C_XLEN  new PC; bits [1:0] forced to 0.
- halt_i  input  1  stop issuing; drain in-flight responses.
- idle_o  output  1  high in IDLE.
- req_valid_o  output  1  fetch request valid.
- req_ready_i  input  1  memory accepts request.
- req_addr_o  output  C_XLEN  fetch address.
- resp_valid_i  input  1  in-order response valid (always accepted).
- resp_data_i  input  32  instruction word.
- resp_err_i  input  1  bus error (used only with FETCH_ERR_EN).
- fifo_flush_o  output  1  FIFO flush.
- fifo_wr_o  output  1  FIFO write.
- fifo_din_o  output  C_XLEN+33  {err, pc, instr}.
- fifo_rd_i  input  1  consumer pop, same signal driving the FIFO read.

## Operation
- Counters:
  - level, 0..D: FIFO occupancy, +fifo_wr_o, −fifo_rd_i.
  - live: outstanding requests whose responses will be written.
  - discard: outstanding requests whose responses are dropped.
- PC registers: fetch_pc (next request address, drives req_addr_o) and resp_pc (PC of the oldest live response).
- Accept = req_valid_o & req_ready_i. It increments live and advances fetch_pc by 4 (wraps mod 2**C_XLEN).
- Credit: req_valid_o = (state==FETCH) & (level+live < D) & (live+discard < C_MAX_OUTSTANDING). Use registered counter values only; req_valid_o must not depend on redirect_i, resp_valid_i or fifo_rd_i.
- Response handling:
  - If discard>0: drop the response, discard−1.
  - Otherwise: fifo_wr_o=1 combinationally, fifo_din_o={err,resp_pc,resp_data_i}, live−1, resp_pc+4.
- Redirect cycle:
  - fifo_flush_o=1; any response this cycle is dropped (fifo_wr_o=0).
  - Next state: level=0; discard = discard+live (+1 if accept this cycle) (−1 if response this cycle); live=0; fetch_pc=resp_pc=redirect_pc_i&~3.
- States:
  - IDLE (reset state): no requests. redirect_i → FETCH.
  - FETCH: issue per credit. halt_i → DRAIN.
  - DRAIN: no requests; responses handled normally. When live+discard==0 → IDLE.
  - Redirect in any state → FETCH, or → DRAIN if halt_i is also high. halt_i in IDLE is ignored.
- fifo_rd_i when level==0 is a consumer error: level holds at 0.

## Timing
- Reset values: state=IDLE, idle_o=1, req_valid_o=0, req_addr_o=0, fifo_wr_o=0, fifo_flush_o=1 (fifo_flush_o = reset_i | redirect_i), all counters 0.
- Redirect at cycle N: fifo_flush_o high in N; req_valid_o may first be high in N+1 with req_addr_o=redirect PC.
- Response to FIFO write: 0 cycles (combinational).
- A simultaneous write and pop leaves level unchanged.
- A pop in cycle N frees credit visible in req_valid_o at N+1.

## Configuration
- FETCH_ERR_EN defined:
  - A live response with resp_err_i=1 is written with err=1, then state → FAULT.
  - FAULT: no requests; all remaining live responses are dropped (live moved to discard).
  - Exit FAULT only on redirect_i (→ FETCH, or DRAIN with halt_i). idle_o=0 in FAULT.
- FETCH_ERR_EN undefined: resp_err_i ignored, err bit always 0, FAULT state not implemented.

## Test plan
- Reset, redirect PC=0x100, req_ready_i=1, 1-cycle response latency, no pops → exactly 4 requests 0x100..0x10C; req_valid_o low once level+live==4; FIFO holds pc 0x100..0x10C in order.
- From the full state, pop once → one new request at 0x110 issued the following cycle; entry written with pc 0x110.
- 3 requests outstanding, redirect to 0x203 → flush, next request at 0x200, 3 stale responses dropped, first FIFO write has pc 0x200.
- Redirect in the same cycle as an accept and a response → discard = old live+1−1; no FIFO write that cycle.
- halt_i with 2 outstanding → no new requests, 2 entries written, idle_o high the cycle after the last response.
- With FETCH_ERR_EN: second response has err=1 → entry err=1, third response dropped, no further requests until redirect; without the macro, the same entry has err=0 and fetching continues.
